// File: rtl/cnn_layer_accel_quad_job_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_quad_job_ctrl
//
// Responder side of the quad job-control protocol. It accepts a job from the
// host-side initiator and latches the descriptor into per-field configuration
// registers. It then runs the buffer-fetch handshake, starts the core
// datapath, and holds job_complete until the initiator acknowledges it.
//
// Ports
//   clk_if                 : single clock, rising edge
//   rst                    : asynchronous, active-low reset
//   job_start / job_accept : job request in, one-cycle acknowledge out
//   job_parameters         : 128-bit descriptor, sampled with job_start
//   job_fetch_request      : asks the initiator to load buffers
//   job_fetch_ack          : initiator has seen the fetch request
//   job_fetch_complete     : buffers loaded
//   job_complete / _ack    : job finished (held) and its acknowledge
//   core_start / core_done : one-cycle datapath start and datapath finished
//   *_cfg                  : decoded descriptor fields, held until next accept
//   job_busy               : high whenever the controller is not idle
//   fetch_timeout_err      : sticky, set when a fetch request is never acked
//   job_count              : completed-job counter, wraps
// ---------------------------------------------------------------------------
module cnn_layer_accel_quad_job_ctrl #(
  parameter int FETCH_TIMEOUT = 1024,
  parameter int JOB_CNT_W     = 16
) (
  input  logic                 clk_if,
  input  logic                 rst,
  input  logic                 job_start,
  output logic                 job_accept,
  input  logic [127:0]         job_parameters,
  output logic                 job_fetch_request,
  input  logic                 job_fetch_ack,
  input  logic                 job_fetch_complete,
  output logic                 job_complete,
  input  logic                 job_complete_ack,
  output logic                 core_start,
  input  logic                 core_done,
  output logic [9:0]           num_input_cols_cfg,
  output logic [9:0]           num_input_rows_cfg,
  output logic [6:0]           num_kernel_cfg,
  output logic [4:0]           kernel_size_cfg,
  output logic [4:0]           padding_cfg,
  output logic [6:0]           convolution_stride_cfg,
  output logic                 job_busy,
  output logic                 fetch_timeout_err,
  output logic [JOB_CNT_W-1:0] job_count
);

  localparam int TO_W = $clog2(FETCH_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCEPT     = 3'd1,
    FETCH_REQ  = 3'd2,
    FETCH_WAIT = 3'd3,
    RUN        = 3'd4,
    COMPLETE   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [9:0]             cols_q, cols_d;
  logic [9:0]             rows_q, rows_d;
  logic [6:0]             nkern_q, nkern_d;
  logic [4:0]             ksize_q, ksize_d;
  logic [4:0]             pad_q, pad_d;
  logic [6:0]             stride_q, stride_d;
  logic                   err_q, err_d;
  logic [JOB_CNT_W-1:0]   count_q, count_d;
  logic                   accept_q, accept_d;
  logic                   fetch_req_q, fetch_req_d;
  logic                   core_start_q, core_start_d;
  logic                   complete_q, complete_d;
  logic                   busy_q, busy_d;

  // Descriptor bits above the decoded fields are reserved.
  logic unused_rsv;
  assign unused_rsv = ^job_parameters[127:44];

  // Next-state, datapath and output decode. Every output flop is loaded from
  // the next state, so outputs line up with the state they describe while
  // staying free of combinational paths from the inputs.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    cols_d   = cols_q;
    rows_d   = rows_q;
    nkern_d  = nkern_q;
    ksize_d  = ksize_q;
    pad_d    = pad_q;
    stride_d = stride_q;
    err_d    = err_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (job_start) begin
          cols_d   = job_parameters[9:0];
          rows_d   = job_parameters[19:10];
          nkern_d  = job_parameters[26:20];
          ksize_d  = job_parameters[31:27];
          pad_d    = job_parameters[36:32];
          stride_d = job_parameters[43:37];
          state_d  = ACCEPT;
        end
      end
      ACCEPT: begin
        to_cnt_d = '0;
        state_d  = FETCH_REQ;
      end
      FETCH_REQ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // An ack in the last permitted cycle still wins over the timeout.
        if (job_fetch_ack) begin
          state_d = job_fetch_complete ? RUN : FETCH_WAIT;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      FETCH_WAIT: begin
        if (job_fetch_complete) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        if (job_complete_ack) begin
          count_d = count_q + JOB_CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept_d     = (state_d == ACCEPT);
    fetch_req_d  = (state_d == FETCH_REQ);
    core_start_d = (state_d == RUN) && (state_q != RUN);
    complete_d   = (state_d == COMPLETE);
    busy_d       = (state_d != IDLE);
  end

  // State, configuration and status registers.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      cols_q       <= '0;
      rows_q       <= '0;
      nkern_q      <= '0;
      ksize_q      <= '0;
      pad_q        <= '0;
      stride_q     <= '0;
      err_q        <= 1'b0;
      count_q      <= '0;
      accept_q     <= 1'b0;
      fetch_req_q  <= 1'b0;
      core_start_q <= 1'b0;
      complete_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      nkern_q      <= nkern_d;
      ksize_q      <= ksize_d;
      pad_q        <= pad_d;
      stride_q     <= stride_d;
      err_q        <= err_d;
      count_q      <= count_d;
      accept_q     <= accept_d;
      fetch_req_q  <= fetch_req_d;
      core_start_q <= core_start_d;
      complete_q   <= complete_d;
      busy_q       <= busy_d;
    end
  end

  assign job_accept             = accept_q;
  assign job_fetch_request      = fetch_req_q;
  assign core_start             = core_start_q;
  assign job_complete           = complete_q;
  assign job_busy               = busy_q;
  assign fetch_timeout_err      = err_q;
  assign job_count              = count_q;
  assign num_input_cols_cfg     = cols_q;
  assign num_input_rows_cfg     = rows_q;
  assign num_kernel_cfg         = nkern_q;
  assign kernel_size_cfg        = ksize_q;
  assign padding_cfg            = pad_q;
  assign convolution_stride_cfg = stride_q;

endmodule

// File: tb/tb_cnn_layer_accel_quad_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_accel_quad_job_ctrl
//
// Directed bench for the quad job controller, built with a short fetch
// timeout (8) and a 2-bit job counter so timeout and wrap are reachable.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_cnn_layer_accel_quad_job_ctrl;

  logic         clk_if;
  logic         rst;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic         core_start;
  logic         core_done;
  logic [9:0]   num_input_cols_cfg;
  logic [9:0]   num_input_rows_cfg;
  logic [6:0]   num_kernel_cfg;
  logic [4:0]   kernel_size_cfg;
  logic [4:0]   padding_cfg;
  logic [6:0]   convolution_stride_cfg;
  logic         job_busy;
  logic         fetch_timeout_err;
  logic [1:0]   job_count;

  int checks = 0;
  int errors = 0;
  int acceptCount = 0;
  int startCount = 0;
  int fetchReqCount = 0;

  cnn_layer_accel_quad_job_ctrl #(
    .FETCH_TIMEOUT(8),
    .JOB_CNT_W(2)
  ) dut (
    .clk_if(clk_if),
    .rst(rst),
    .job_start(job_start),
    .job_accept(job_accept),
    .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request),
    .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete),
    .job_complete_ack(job_complete_ack),
    .core_start(core_start),
    .core_done(core_done),
    .num_input_cols_cfg(num_input_cols_cfg),
    .num_input_rows_cfg(num_input_rows_cfg),
    .num_kernel_cfg(num_kernel_cfg),
    .kernel_size_cfg(kernel_size_cfg),
    .padding_cfg(padding_cfg),
    .convolution_stride_cfg(convolution_stride_cfg),
    .job_busy(job_busy),
    .fetch_timeout_err(fetch_timeout_err),
    .job_count(job_count)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk_if = 1'b0;
    forever #5 clk_if = ~clk_if;
  end

  // Pulse/level counters sampled mid-cycle; tests diff them around a window.
  always @(negedge clk_if) begin
    if (job_accept) acceptCount++;
    if (core_start) startCount++;
    if (job_fetch_request) fetchReqCount++;
  end

  // Absolute guard so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk_if);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] mkParams(input logic [83:0] rsv,
                                            input logic [6:0] stride,
                                            input logic [4:0] pad,
                                            input logic [4:0] ks,
                                            input logic [6:0] nk,
                                            input logic [9:0] rows,
                                            input logic [9:0] cols);
    return {rsv, stride, pad, ks, nk, rows, cols};
  endfunction

  task automatic checkCfg(input string tag, input int cols, input int rows,
                          input int nk, input int ks, input int pad,
                          input int stride);
    checkOutput({tag, "_cols"}, 32'(num_input_cols_cfg), cols);
    checkOutput({tag, "_rows"}, 32'(num_input_rows_cfg), rows);
    checkOutput({tag, "_nkern"}, 32'(num_kernel_cfg), nk);
    checkOutput({tag, "_ksize"}, 32'(kernel_size_cfg), ks);
    checkOutput({tag, "_pad"}, 32'(padding_cfg), pad);
    checkOutput({tag, "_stride"}, 32'(convolution_stride_cfg), stride);
  endtask

  // Runs one full job. cmplWait=0 drives ack and fetch_complete together;
  // doneWait=0 returns core_done in the core_start cycle.
  task automatic applyStimulus(input string name, input logic [127:0] params,
                               input int ackWait, input int cmplWait,
                               input int doneWait, input int cackWait,
                               input int expCount);
    int acc0;
    int st0;
    acc0 = acceptCount;
    st0 = startCount;
    job_parameters = params;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    checkOutput({name, "_accept"}, 32'(job_accept), 1);
    tick();
    checkOutput({name, "_fetch_req"}, 32'(job_fetch_request), 1);
    repeat (ackWait) tick();
    job_fetch_ack = 1'b1;
    if (cmplWait == 0) job_fetch_complete = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    job_fetch_complete = 1'b0;
    checkOutput({name, "_fetch_req_drop"}, 32'(job_fetch_request), 0);
    if (cmplWait > 0) begin
      repeat (cmplWait - 1) tick();
      checkOutput({name, "_no_early_start"}, 32'(core_start), 0);
      job_fetch_complete = 1'b1;
      tick();
      job_fetch_complete = 1'b0;
    end
    checkOutput({name, "_core_start"}, 32'(core_start), 1);
    if (doneWait == 0) begin
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
    end else begin
      tick();
      checkOutput({name, "_start_one_cycle"}, 32'(core_start), 0);
      repeat (doneWait - 1) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
    end
    checkOutput({name, "_complete"}, 32'(job_complete), 1);
    repeat (cackWait) tick();
    checkOutput({name, "_complete_held"}, 32'(job_complete), 1);
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    checkOutput({name, "_complete_drop"}, 32'(job_complete), 0);
    checkOutput({name, "_count"}, 32'(job_count), expCount);
    checkOutput({name, "_idle"}, 32'(job_busy), 0);
    checkOutput({name, "_accept_pulses"}, acceptCount - acc0, 1);
    checkOutput({name, "_start_pulses"}, startCount - st0, 1);
  endtask

  initial begin
    logic [127:0] pNom;
    logic [127:0] pHeld1;
    logic [127:0] pHeld2;
    logic [127:0] pMisc;
    int acc0;
    int fr0;

    pNom   = mkParams(84'hDEAD_BEEF_CAFE, 7'd1, 5'd1, 5'd3, 7'd5, 10'd224, 10'd224);
    pHeld1 = mkParams(84'h0, 7'd3, 5'd2, 5'd7, 7'd64, 10'd33, 10'd17);
    pHeld2 = mkParams({84{1'b1}}, 7'h7F, 5'h1F, 5'h1F, 7'h7F, 10'h3FF, 10'h3FF);
    pMisc  = mkParams(84'h0, 7'd2, 5'd0, 5'd5, 7'd9, 10'd100, 10'd50);

    rst = 1'b0;
    job_start = 1'b0;
    job_parameters = '0;
    job_fetch_ack = 1'b0;
    job_fetch_complete = 1'b0;
    job_complete_ack = 1'b0;
    core_done = 1'b0;

    // Power-on reset state.
    repeat (3) tick();
    checkOutput("rst_busy", 32'(job_busy), 0);
    checkOutput("rst_accept", 32'(job_accept), 0);
    checkOutput("rst_fetch_req", 32'(job_fetch_request), 0);
    checkOutput("rst_complete", 32'(job_complete), 0);
    checkOutput("rst_core_start", 32'(core_start), 0);
    checkOutput("rst_err", 32'(fetch_timeout_err), 0);
    checkOutput("rst_count", 32'(job_count), 0);
    checkCfg("rst_cfg", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();

    // Reset asserted asynchronously in the core_start cycle of a job.
    job_parameters = pMisc;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    tick();
    job_fetch_ack = 1'b1;
    job_fetch_complete = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    job_fetch_complete = 1'b0;
    checkOutput("midrun_core_start", 32'(core_start), 1);
    checkOutput("midrun_cfg_loaded", 32'(num_input_cols_cfg), 50);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrun_rst_start", 32'(core_start), 0);
    checkOutput("midrun_rst_busy", 32'(job_busy), 0);
    checkOutput("midrun_rst_count", 32'(job_count), 0);
    checkCfg("midrun_rst_cfg", 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("midrun_no_complete", 32'(job_complete), 0);
    rst = 1'b1;
    tick();

    // Nominal job with spaced-out responses.
    applyStimulus("nominal", pNom, 3, 5, 10, 2, 1);
    checkCfg("nominal_cfg", 224, 224, 5, 3, 1, 1);

    // job_start held 20 edges; core_done during FETCH_WAIT must be ignored.
    acc0 = acceptCount;
    job_parameters = pHeld1;
    job_start = 1'b1;
    tick();
    checkOutput("held_accept", 32'(job_accept), 1);
    job_parameters = pHeld2;
    tick();
    job_fetch_ack = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    core_done = 1'b1;
    repeat (17) tick();
    core_done = 1'b0;
    job_start = 1'b0;
    checkOutput("held_one_accept", acceptCount - acc0, 1);
    checkOutput("held_wait_no_complete", 32'(job_complete), 0);
    checkOutput("held_wait_busy", 32'(job_busy), 1);
    checkCfg("held_cfg", 17, 33, 64, 7, 2, 3);
    job_fetch_complete = 1'b1;
    tick();
    job_fetch_complete = 1'b0;
    checkOutput("held_core_start", 32'(core_start), 1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkOutput("held_complete", 32'(job_complete), 1);
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    checkOutput("held_count", 32'(job_count), 2);

    // Ack and fetch_complete together skip FETCH_WAIT.
    applyStimulus("simul", pMisc, 1, 0, 2, 0, 3);

    // Fetch timeout: never ack.
    fr0 = fetchReqCount;
    job_parameters = pMisc;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    checkOutput("to_accept", 32'(job_accept), 1);
    checkOutput("to_err_before", 32'(fetch_timeout_err), 0);
    for (int i = 0; i < 40 && job_busy; i++) tick();
    checkOutput("to_busy", 32'(job_busy), 0);
    checkOutput("to_req_cycles", fetchReqCount - fr0, 8);
    checkOutput("to_err", 32'(fetch_timeout_err), 1);
    checkOutput("to_count", 32'(job_count), 3);
    checkCfg("to_cfg_kept", 50, 100, 9, 5, 0, 2);
    applyStimulus("after_to", pNom, 2, 1, 1, 1, 0);
    checkOutput("to_err_sticky", 32'(fetch_timeout_err), 1);

    // Counter wrap over five back-to-back minimal jobs.
    rst = 1'b0;
    #1;
    checkOutput("wrap_rst_err", 32'(fetch_timeout_err), 0);
    checkOutput("wrap_rst_count", 32'(job_count), 0);
    tick();
    rst = 1'b1;
    tick();
    applyStimulus("wrap1", pMisc, 0, 0, 0, 0, 1);
    applyStimulus("wrap2", pMisc, 0, 0, 0, 0, 2);
    applyStimulus("wrap3", pMisc, 0, 0, 0, 0, 3);
    applyStimulus("wrap4", pMisc, 0, 0, 0, 0, 0);
    applyStimulus("wrap5", pMisc, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
